// File: rtl/instr_loader.sv
// instr_loader: fills instruction memory from a byte stream while holding the core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (adds CHECK and ERR states).
module instr_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] len_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [ADDR_WIDTH-2:0] MAX_WORDS = {1'b1, {IDX_W{1'b0}}};
    localparam logic [ADDR_WIDTH-2:0] ONE_WORD  = {{IDX_W{1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, ERR, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

    state_t                state;
    state_t                next_state;
    logic [1:0]            byte_cnt;
    logic [IDX_W-1:0]      word_idx;
    logic [IDX_W-1:0]      last_idx;
    logic [31:0]           buffer;
    logic [ADDR_WIDTH-2:0] len_clamped;
    logic                  accept;
    logic                  last_word;

    // Lengths beyond the memory size are clamped so the word index never wraps.
    assign len_clamped = (len_words > MAX_WORDS) ? MAX_WORDS : len_words;
    assign last_word   = (word_idx == last_idx);
    assign mem_addr    = {word_idx, 2'b00};
    assign mem_wdata   = buffer;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
    logic       err_q;
    assign accept = start && (len_words != '0) && (state == IDLE || state == ERR);
    assign err    = err_q;
`else
    assign accept = start && (len_words != '0) && (state == IDLE);
    assign err    = 1'b0;
`endif

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) next_state = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                next_state = last_word ? CHECK : LOAD;
`else
                next_state = last_word ? DONE : LOAD;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) next_state = (in_data == xor_acc) ? DONE : ERR;
            end
            ERR: begin
                busy = 1'b0;
                if (accept) next_state = LOAD;
            end
`endif
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cpu_rst  <= 1'b1;
            byte_cnt <= 2'd0;
            word_idx <= '0;
            last_idx <= '0;
            buffer   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= 8'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            // Registered so the core stays in reset on the first cycle out of reset.
            cpu_rst <= (next_state != IDLE);
            if (accept) begin
                last_idx <= IDX_W'(len_clamped - ONE_WORD);
                byte_cnt <= 2'd0;
                word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                xor_acc  <= 8'd0;
                err_q    <= 1'b0;
`endif
            end
            if (state == LOAD && in_valid) begin
                buffer[{byte_cnt, 3'b000} +: 8] <= in_data;
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                xor_acc  <= xor_acc ^ in_data;
`endif
            end
            if (state == WRITE) word_idx <= word_idx + IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
            if (state == CHECK && in_valid && in_data != xor_acc) err_q <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: session-level reference model plus directed literal checks.
module tb_instr_loader;
  localparam int AW   = 12;
  localparam int MAXW = 1 << (AW - 2);
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          start     = 1'b0;
  logic [AW-2:0] len_words = '0;
  logic          in_valid  = 1'b0;
  logic [7:0]    in_data   = 8'd0;
  logic          in_ready, mem_we, cpu_rst, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]    stream[$];
  logic [AW-1:0] wlog_a[$];
  logic [31:0]   wlog_d[$];
  int            done_cyc = -1;
  int            start_cyc = 0;
  bit            done_seen = 1'b0;
  bit            prev_done = 1'b0;
  bit            rst_after_done = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks a session as "words written / bytes gathered" counts.
  bit         m_active = 1'b0, m_wr = 1'b0, m_done = 1'b0, m_chk = 1'b0;
  bit         m_errst = 1'b0, m_err = 1'b0;
  bit         m_cpu_rst = 1'b1;
  int         m_len = 0, m_words = 0, m_bytes = 0;
  logic [7:0] m_x = 8'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_chk = 1'b0;
      m_errst = 1'b0; m_err = 1'b0; m_cpu_rst = 1'b1;
      m_words = 0; m_bytes = 0;
    end else begin
      if (m_done) begin
        m_done = 1'b0; m_active = 1'b0;
      end else if (!m_active) begin
        if (start && len_words != 0) begin
          m_active = 1'b1; m_errst = 1'b0; m_err = 1'b0;
          m_len = (int'(len_words) > MAXW) ? MAXW : int'(len_words);
          m_words = 0; m_bytes = 0; m_x = 8'd0;
        end
      end else if (m_wr) begin
        m_wr = 1'b0;
        m_words++;
        if (m_words == m_len) begin
          if (CHK) m_chk = 1'b1;
          else m_done = 1'b1;
        end
      end else if (m_chk) begin
        if (in_valid) begin
          m_chk = 1'b0;
          if (in_data == m_x) m_done = 1'b1;
          else begin m_active = 1'b0; m_errst = 1'b1; m_err = 1'b1; end
        end
      end else if (in_valid) begin
        m_x = m_x ^ in_data;
        m_bytes++;
        if (m_bytes == 4) begin m_wr = 1'b1; m_bytes = 0; end
      end
      m_cpu_rst = m_active || m_errst;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] expw;
    int idx;
    check("ctrl{rdy,we,busy,done,err,cpu_rst}",
          {in_ready, mem_we, busy, done, err, cpu_rst},
          {m_active && !m_wr && !m_done, m_wr, m_active, m_done, m_err, m_cpu_rst});
    if (!rst) begin
      check("reset_addr_data", {mem_addr, mem_wdata}, 64'd0);
    end else if (m_wr) begin
      idx  = m_words * 4;
      expw = 32'd0;
      if (idx + 3 < stream.size())
        expw = {stream[idx + 3], stream[idx + 2], stream[idx + 1], stream[idx]};
      check("write_addr_data", {mem_addr, mem_wdata}, {AW'(idx), expw});
    end
    if (mem_we) begin wlog_a.push_back(mem_addr); wlog_d.push_back(mem_wdata); end
    if (done) begin done_cyc = cyc; done_seen = 1'b1; end
    if (prev_done) rst_after_done = cpu_rst;
    prev_done = done;
  end

  task automatic fill_random(input int nbytes);
    stream.delete();
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // mode: 0 = full rate, 1 = valid every other cycle, 2 = random valid.
  task automatic run_session(input int len, input int mode, input int abort_at,
                             input int glitch_at, input bit bad_sum);
    int leff, need, k, t;
    bit v, r;
    logic [7:0] x;
    leff = (len > MAXW) ? MAXW : len;
    wlog_a.delete(); wlog_d.delete();
    done_seen = 1'b0;
    if (CHK && leff > 0) begin
      x = 8'd0;
      for (int i = 0; i < leff * 4; i++) x = x ^ stream[i];
      stream.push_back(bad_sum ? (x ^ 8'h01) : x);
    end
    need = (leff == 0) ? 0 : leff * 4 + (CHK ? 1 : 0);
    @(posedge clk); #1;
    start = 1'b1; len_words = len[AW-2:0];
    @(posedge clk); #1;
    start = 1'b0; start_cyc = cyc;
    k = 0; t = 0;
    while (k < need && t < 20000) begin
      if (abort_at >= 0 && k == abort_at) begin
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check("abort_outputs",
                 {in_ready, mem_we, busy, done, err, cpu_rst, mem_addr, mem_wdata},
                 {5'b00000, 1'b1, {AW{1'b0}}, 32'd0});
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = v ? stream[k] : 8'($urandom);
      start    = (glitch_at >= 0 && k == glitch_at);
      if (start) len_words = 7;
      r = in_ready;
      @(posedge clk); #1;
      if (v && r) k++;
      t++;
    end
    start = 1'b0;
    check("bytes_consumed", 64'(k), 64'(need));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("reset_state", {in_ready, mem_we, busy, done, err, cpu_rst}, 64'b000001);
    rst = 1'b1;
    @(posedge clk); #1;
    check("cpu_rst_after_release", {63'd0, cpu_rst}, 64'd0);

    // Directed two-word load at full rate.
    stream = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    fork
      begin
        @(posedge clk); @(posedge clk); #1;
        check("ready_after_start", {62'd0, in_ready, busy}, 64'b11);
      end
      run_session(2, 0, -1, -1, 1'b0);
    join
    check("t1_nwrites", 64'(wlog_a.size()), 64'd2);
    check("t1_w0", {wlog_a[0], wlog_d[0]}, {12'h000, 32'h00500013});
    check("t1_w1", {wlog_a[1], wlog_d[1]}, {12'h004, 32'h00100093});
    check("t1_done_latency", 64'(done_cyc - start_cyc), CHK ? 64'd11 : 64'd10);
    check("t1_cpu_rst_after_done", {63'd0, rst_after_done}, 64'd0);

    // Same stream, valid every other cycle.
    stream = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_session(2, 1, -1, -1, 1'b0);
    check("t2_nwrites", 64'(wlog_a.size()), 64'd2);
    check("t2_w0", {wlog_a[0], wlog_d[0]}, {12'h000, 32'h00500013});
    check("t2_w1", {wlog_a[1], wlog_d[1]}, {12'h004, 32'h00100093});

    // Zero-length start is ignored.
    wlog_a.delete(); wlog_d.delete();
    @(posedge clk); #1; start = 1'b1; len_words = '0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("len0_busy_cpu_rst", {62'd0, busy, cpu_rst}, 64'd0);
    check("len0_nwrites", 64'(wlog_a.size()), 64'd0);

    // Start pulsed mid-load is ignored.
    fill_random(12);
    run_session(3, 2, -1, 2, 1'b0);
    check("glitch_nwrites", 64'(wlog_a.size()), 64'd3);

    // Reset after 6 bytes of a 3-word load.
    fill_random(12);
    run_session(3, 0, 6, -1, 1'b0);
    check("abort_nwrites", 64'(wlog_a.size()), 64'd1);
    check("abort_w0_addr", 64'(wlog_a[0]), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_release_cpu_rst", {63'd0, cpu_rst}, 64'd0);

    // Randomized sessions.
    for (int s = 0; s < 6; s++) begin
      int l;
      l = $urandom_range(1, 5);
      fill_random(l * 4);
      run_session(l, 2, -1, -1, 1'b0);
      check("rand_nwrites", 64'(wlog_a.size()), 64'(l));
    end

    // Oversized length clamps to the full memory without wrapping.
    fill_random(MAXW * 4);
    run_session(1500, 0, -1, -1, 1'b0);
    check("clamp_nwrites", 64'(wlog_a.size()), 64'(MAXW));
    check("clamp_last_addr", 64'(wlog_a[wlog_a.size() - 1]), 64'hFFC);

`ifdef LOADER_CHECKSUM_EN
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session(1, 0, -1, -1, 1'b0);
    check("chk_good_word", {wlog_a[0], wlog_d[0]}, {12'h000, 32'hEFBEADDE});
    check("chk_good_done_err", {62'd0, done_seen, err}, 64'b10);
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session(1, 0, -1, -1, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("chk_bad_err_cpu_rst_busy", {61'd0, err, cpu_rst, busy}, 64'b110);
    check("chk_bad_no_done", {63'd0, done_seen}, 64'd0);
    fill_random(4);
    run_session(1, 0, -1, -1, 1'b0);
    check("chk_restart_clears_err", {62'd0, done_seen, err}, 64'b10);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
